// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative HI/LO multiply/divide unit.
package mult_div_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  localparam int          ITERATIONS  = 32;
  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

  function automatic logic op_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_step.sv
// One iteration of shift-add multiply or restoring divide.
// Divide branch present only with MULT_DIV_DIVIDE_EN.
module mult_div_step #(
  parameter int W = 32
) (
  input  logic           i_is_div,
  input  logic [2*W-1:0] i_acc,
  input  logic [W-1:0]   i_opnd,
  output logic [2*W-1:0] o_acc
);

  logic [W:0]     w_sum;
  logic [2*W-1:0] w_mul;

  // {partial product, remaining multiplier bits}
  assign w_sum = {1'b0, i_acc[2*W-1:W]}
               + {1'b0, (i_acc[0] ? i_opnd : {W{1'b0}})};
  assign w_mul = {w_sum, i_acc[W-1:1]};

`ifdef MULT_DIV_DIVIDE_EN
  logic [W+1:0]   w_diff;
  logic [2*W-1:0] w_div;

  // {remainder, quotient}; shifted remainder is W+1 bits
  assign w_diff = {1'b0, i_acc[2*W-1:W-1]} - {2'b00, i_opnd};
  assign w_div  = w_diff[W+1]
                ? {i_acc[2*W-2:0], 1'b0}
                : {w_diff[W-1:0], i_acc[W-2:0], 1'b1};
  assign o_acc  = i_is_div ? w_div : w_mul;
`else
  assign o_acc  = i_is_div ? i_acc : w_mul;
`endif

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit, 33-cycle latency.
// Divide support enabled by defining MULT_DIV_DIVIDE_EN.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W  = WIDTH;
  localparam int CW = $clog2(ITERATIONS);

  state_e         r_state;
  state_e         w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_opnd;
  logic           r_is_div;
  logic           r_neg_q;
  logic           r_neg_r;
  logic           r_dz;
  logic [W-1:0]   r_hi;
  logic [W-1:0]   r_lo;
  logic           r_done;

  logic           w_launch;
  logic           w_reject;
  logic           w_mt_en;
  logic           w_fix;
  logic           w_signed;
  logic           w_rs_neg;
  logic           w_rt_neg;
  logic [W-1:0]   w_rs_mag;
  logic [W-1:0]   w_rt_mag;
  logic [2*W-1:0] w_step;
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_quot;
  logic [W-1:0]   w_rem;
  logic [2*W-1:0] w_res;

  assign w_signed = op_signed(op_e'(op));
  assign w_rs_neg = w_signed & rs_data[W-1];
  assign w_rt_neg = w_signed & rt_data[W-1];
  assign w_rs_mag = w_rs_neg ? -rs_data : rs_data;
  assign w_rt_mag = w_rt_neg ? -rt_data : rt_data;

  mult_div_step #(.W(W)) u_step (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc    (w_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_launch) w_state_nxt = ST_CALC;
      ST_CALC: if (r_cnt == CW'(ITERATIONS-1)) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != ST_IDLE);
    w_fix    = (r_state == ST_FIX);
    w_launch = 1'b0;
    w_reject = 1'b0;
    w_mt_en  = 1'b0;
    if (r_state == ST_IDLE) begin
      w_mt_en  = ~start;
`ifdef MULT_DIV_DIVIDE_EN
      w_launch = start;
`else
      w_launch = start & ~op[1];
      w_reject = start &  op[1];
`endif
    end
  end

  // Quotient takes the XOR sign, remainder the dividend sign
  always_comb begin
    w_prod = r_neg_q ? -r_acc : r_acc;
    w_quot = r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0];
    w_rem  = r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
    if (r_dz) w_quot = W'(DIV_ZERO_LO);
    w_res  = r_is_div ? {w_rem, w_quot} : w_prod;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_fix | w_reject;
      if (w_launch) begin
        r_cnt    <= '0;
        r_acc    <= {{W{1'b0}}, w_rs_mag};
        r_opnd   <= w_rt_mag;
        r_is_div <= op[1];
        r_neg_q  <= w_rs_neg ^ w_rt_neg;
        r_neg_r  <= w_rs_neg;
        r_dz     <= op[1] & (rt_data == '0);
      end else if (r_state == ST_CALC) begin
        r_acc <= w_step;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_fix) begin
        r_hi <= w_res[2*W-1:W];
        r_lo <= w_res[W-1:0];
      end else if (w_mt_en) begin
        if (mthi) r_hi <= rs_data;
        if (mtlo) r_lo <= rs_data;
      end
    end
  end

  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against an arithmetic model.
module tb_mult_div_unit;
  import mult_div_pkg::*;

`ifdef MULT_DIV_DIVIDE_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] m_hi  = '0;
  logic [31:0] m_lo  = '0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {HI, LO} from plain 64-bit arithmetic
  function automatic logic [63:0] ref_res(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: begin p = 64'(sa * sb); return p; end
      2'b01: begin p = ua * ub; return p; end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
      end
    endcase
  endfunction

  // mode 1: start+mthi during CALC; mode 2: mthi/mtlo alongside start
  task automatic run(input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input string tag,
                     input int mode);
    logic [63:0] r;
    logic [31:0] old_hi, old_lo;
    int          nb, early;
    bit          runs;
    runs   = DIV_EN || !o[1];
    r      = ref_res(o, a, b);
    old_hi = m_hi;
    old_lo = m_lo;
    if (runs) {m_hi, m_lo} = r;
    @(negedge clk);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    mthi    = (mode == 2);
    mtlo    = (mode == 2);
    @(posedge clk);
    #1;
    start   = 1'b0;
    mthi    = 1'b0;
    mtlo    = 1'b0;
    rs_data = $urandom;
    rt_data = $urandom;
    nb      = 0;
    early   = 0;
    while (busy && nb < 40) begin
      if (done) early++;
      if (nb == 8) chk({tag, ".hold"}, {hi, lo}, {old_hi, old_lo});
      if (mode == 1 && nb == 5) begin
        start   = 1'b1;
        mthi    = 1'b1;
        op      = OP_MULT;
        rs_data = 32'h1234;
      end
      if (mode == 1 && nb == 6) begin
        start = 1'b0;
        mthi  = 1'b0;
      end
      @(posedge clk);
      #1;
      nb++;
    end
    start = 1'b0;
    mthi  = 1'b0;
    chk({tag, ".busy_len"}, 64'(nb), runs ? 64'd33 : 64'd0);
    chk({tag, ".early"}, 64'(early), 64'd0);
    chk({tag, ".done"}, {63'd0, done}, 64'd1);
    chk({tag, ".hi"}, {32'd0, hi}, {32'd0, m_hi});
    chk({tag, ".lo"}, {32'd0, lo}, {32'd0, m_lo});
    @(posedge clk);
    #1;
    chk({tag, ".done_off"}, {63'd0, done}, 64'd0);
  endtask

  task automatic mt(input bit h, input bit l, input logic [31:0] v,
                    input string tag);
    @(negedge clk);
    mthi    = h;
    mtlo    = l;
    rs_data = v;
    @(posedge clk);
    #1;
    mthi = 1'b0;
    mtlo = 1'b0;
    if (h) m_hi = v;
    if (l) m_lo = v;
    chk({tag, ".hi"}, {32'd0, hi}, {32'd0, m_hi});
    chk({tag, ".lo"}, {32'd0, lo}, {32'd0, m_lo});
  endtask

  initial begin
    int          seen;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    reset   = 1'b1;
    start   = 1'b0;
    mthi    = 1'b0;
    mtlo    = 1'b0;
    op      = 2'b00;
    rs_data = '0;
    rt_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.hi", {32'd0, hi}, 64'd0);
    chk("rst.lo", {32'd0, lo}, 64'd0);
    chk("rst.busy", {63'd0, busy}, 64'd0);
    chk("rst.done", {63'd0, done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // abort a MULTU partway through CALC
    @(negedge clk);
    start   = 1'b1;
    op      = OP_MULTU;
    rs_data = 32'd7;
    rt_data = 32'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst.state", {hi, lo, 30'd0, busy, done}, 96'd0);
    @(negedge clk);
    reset = 1'b0;
    seen  = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("midrst.quiet", 64'(seen), 64'd0);
    run(OP_MULTU, 32'd7, 32'd6, "multu7x6", 0);

    run(OP_MULT, 32'hFFFF_FFFD, 32'd5, "mult_neg", 0);
    run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 0);
    run(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg", 0);
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 0);
    run(OP_DIVU, 32'd37, 32'd0, "divu_z", 0);
    run(OP_DIV, 32'hFFFF_FFDB, 32'd0, "div_z", 0);
    run(OP_DIV, 32'd10, 32'd3, "div10_3", 0);
    run(OP_MULT, 32'd3, 32'd4, "mult3x4", 0);
    run(OP_MULT, 32'd123, 32'hFFFF_FE38, "busy_ign", 1);
    mt(1'b0, 1'b1, 32'h55, "mtlo");
    mt(1'b1, 1'b0, 32'hCAFE_0001, "mthi");
    mt(1'b1, 1'b1, 32'hABCD, "mtboth");
    run(OP_MULTU, 32'd9, 32'd9, "start_wins", 2);
    run(OP_DIVU, 32'd100, 32'd7, "divu_sw", 2);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      run(ro, ra, rb, $sformatf("rnd%0d", i), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative HI/LO multiply/divide unit sitting directly downstream of the register file in the MIPS datapath. It consumes the two register-file read operands (rs, rt) for MULT/MULTU/DIV/DIVU. It computes the result over 33 cycles, holding `busy` high so the control path can stall, and keeps the result in architectural HI/LO registers. HI/LO are read back by MFHI/MFLO and written directly by MTHI/MTLO.

## Interface
Parameters:
- `WIDTH`, 32: operand, HI and LO width.

Ports:
- `clk`: input, 1, the single clock; all state updates on its rising edge.
- `reset`: input, 1, asynchronous, active-high; clears all state.
- `start`: input, 1, launch the operation selected by `op` using `rs_data`/`rt_data`.
- `op`: input, 2, operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_data`: input, WIDTH, rs operand from register-file ReadData1.
- `rt_data`: input, WIDTH, rt operand from register-file ReadData2.
- `mthi`: input, 1, load HI from `rs_data`.
- `mtlo`: input, 1, load LO from `rs_data`.
- `busy`: output, 1, operation in progress; the upstream stage must stall on any HI/LO access.
- `done`: output, 1, one-cycle pulse when HI/LO hold a new result.
- `hi`: output, WIDTH, HI register.
- `lo`: output, WIDTH, LO register.

## Operation
- States: IDLE, CALC, FIX.
- **IDLE, `start` high at edge k:**
  - Capture the operand magnitudes; signed ops take absolute values.
  - Record the result signs and the op.
  - Clear the iteration counter and go to CALC.
- **CALC:** one iteration per edge, 32 iterations (counter 0..31).
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract on a 64-bit remainder/quotient pair.
  - After iteration 31, go to FIX.
- **FIX (one edge):**
  - Apply sign correction and write HI/LO.
  - Pulse `done`, then return to IDLE.
- **Multiply results:** HI = upper 32 bits and LO = lower 32 bits of the 64-bit product.
  - MULT is two's-complement; MULTU is unsigned.
- **Divide results:** LO = quotient truncated toward zero; HI = remainder, which carries the sign of the dividend (rs).
- **Divide by zero (rt = 0):**
  - Any divide: LO = 0xFFFFFFFF and HI = rs_data as captured.
  - Latency is unchanged.
- **Signed overflow (DIV, rs = 0x80000000, rt = 0xFFFFFFFF):** LO = 0x80000000, HI = 0.
- **MTHI/MTLO:** accepted only in IDLE; they load on the next edge.
  - `mthi` and `mtlo` together load both registers.
  - If `start` is asserted in the same cycle, `start` wins and `mthi`/`mtlo` are ignored.
- **While busy:** `start`, `mthi` and `mtlo` are ignored; HI/LO keep their old values until FIX.
- **Reset (asserted at any time, including mid-operation):** state returns to IDLE; `hi` = `lo` = 0, `busy` = 0, `done` = 0, counter = 0.

## Timing
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0.
- `start` is sampled at edge k. `busy` is high from after edge k until edge k+33.
- HI/LO update at edge k+33. `done` is high for exactly the cycle following edge k+33, and `busy` falls at that same edge.
- Back-to-back: a new `start` may be sampled at edge k+34, the first edge in IDLE.
- MTHI/MTLO: one-edge latency.
- `hi`/`lo` are registered outputs with no combinational path from the inputs.

## Configuration
- **Macro `MULT_DIV_DIVIDE_EN`.**
- **Defined:** DIV/DIVU are implemented as described above.
- **Undefined:**
  - The divide datapath is removed.
  - `start` with op 10 or 11 does not enter CALC; `busy` stays 0.
  - HI/LO are unchanged, and `done` pulses one cycle after the start edge so upstream never hangs.
  - Multiply behaviour and timing are identical in both builds.

## Structure
- **Package `mult_div_pkg`:**
  - op encoding enum (`OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`);
  - state enum (IDLE, CALC, FIX);
  - constant `ITERATIONS` = 32;
  - divide-by-zero LO constant 0xFFFFFFFF.
- **Sub-module `mult_div_step`:** combinational single-iteration datapath.
  - Performs a shift-add step or a restoring-subtract step, selected by op class.
  - Its divide branch sits under `MULT_DIV_DIVIDE_EN`.
- **Top level:** holds the FSM, counter, sign flags, HI/LO and the MTHI/MTLO logic.

## Test plan
- **Reset mid-operation:** reset, then MULTU 7×6, then reset asserted at cycle 10 of CALC → `hi` = `lo` = 0, `busy` = 0, no `done`; a following MULTU 7×6 gives LO = 42.
- **Signed multiply:** MULT rs = 0xFFFFFFFD (−3) × rt = 5 → LO = 0xFFFFFFF1, HI = 0xFFFFFFFF; `done` in the cycle after edge k+33; `busy` high for exactly 33 cycles.
- **Unsigned full-width multiply:** MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001.
- **Signed divide, overflow and divide by zero:**
  - DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
  - DIVU 37 / 0 → LO = 0xFFFFFFFF, HI = 37.
- **Ignored while busy:** `mthi` with rs = 0x1234 and a second `start` during CALC are ignored, and the result is unaffected; `mtlo` with rs = 0x55 in IDLE → LO = 0x55 after one edge.
- **Build without `MULT_DIV_DIVIDE_EN`:** DIV 10 / 3 → `busy` never rises, `done` pulses one cycle after the start edge, HI/LO unchanged; MULT 3×4 → LO = 12.
